// File: rtl/qmc_fx_pkg.sv
// Fixed-point types and helpers shared by the QMC path pipeline.
// Data words are signed Q16.16; products keep one extra bit so an unsigned operand fits.
package qmc_fx_pkg;
  localparam int WIDTH  = 32;
  localparam int FRAC   = 16;
  localparam int WIDE_W = 2*WIDTH + 1;

  typedef logic signed [WIDTH-1:0]  fx_t;
  typedef logic signed [WIDE_W-1:0] fx_wide_t;

  typedef struct packed {
    logic sat;
    fx_t  val;
  } fx_rs_t;

  typedef enum logic [1:0] {IDLE, WAIT_SCALE, RUN, DRAIN} bi_state_t;

  localparam fx_t      FX_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fx_t      FX_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam fx_wide_t FX_HALF = fx_wide_t'(1) <<< (FRAC-1);

  // Round half up (toward +inf on ties), then clamp to the fx_t range.
  function automatic fx_rs_t fx_round_sat(input fx_wide_t p);
    fx_wide_t r;
    fx_rs_t   res;
    r = (p + FX_HALF) >>> FRAC;
    if (r > fx_wide_t'(FX_MAX)) begin
      res.sat = 1'b1;
      res.val = FX_MAX;
    end else if (r < fx_wide_t'(FX_MIN)) begin
      res.sat = 1'b1;
      res.val = FX_MIN;
    end else begin
      res.sat = 1'b0;
      res.val = r[WIDTH-1:0];
    end
    return res;
  endfunction
endpackage

// File: rtl/fx_mul_rs.sv
// Two-stage signed x unsigned fixed-point multiply with round/saturate.
// Both stages advance only on en_i; valid and a one-bit tag ride along.
module fx_mul_rs
  import qmc_fx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             tag_i,
  input  fx_t              a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic             tag_o,
  output logic             sat_o,
  output fx_t              data_o
);

  fx_wide_t p_q;
  logic     v1_q, t1_q;
  logic     v2_q, t2_q, s2_q;
  fx_t      d2_q;
  fx_rs_t   rs;

  assign rs = fx_round_sat(p_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= '0;
      v1_q <= 1'b0;
      t1_q <= 1'b0;
      v2_q <= 1'b0;
      t2_q <= 1'b0;
      s2_q <= 1'b0;
      d2_q <= '0;
    end else if (en_i) begin
      p_q  <= fx_wide_t'(a_i) * fx_wide_t'($signed({1'b0, b_i}));
      v1_q <= valid_i;
      t1_q <= valid_i & tag_i;
      v2_q <= v1_q;
      t2_q <= v1_q & t1_q;
      s2_q <= v1_q & rs.sat;
      d2_q <= v1_q ? rs.val : '0;
    end
  end

  assign valid_o = v2_q;
  assign tag_o   = t2_q;
  assign sat_o   = s2_q;
  assign data_o  = d2_q;

endmodule

// File: rtl/brownian_increment.sv
// Brownian increment generator: dW = sqrt(dt) * z, n_steps increments per path.
// state      | meaning
// IDLE       | waiting for start
// WAIT_SCALE | path armed, waiting for sqrt(dt) from the sqrt stage
// RUN        | accepting z samples until remaining reaches 0
// DRAIN      | flushing the pipeline until the last dW is taken
module brownian_increment
  import qmc_fx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             sqrt_valid,
  input  logic [WIDTH-1:0] sqrt_in,
  input  logic             z_valid,
  input  logic [WIDTH-1:0] z_data,
  output logic             z_ready,
  output logic             dw_valid,
  output logic [WIDTH-1:0] dw_data,
  output logic             dw_last,
  input  logic             dw_ready,
  output logic             busy,
  output logic             done,
  output logic             sat_flag
);

  bi_state_t        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] scale_q, scale_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             adv, z_hs, z_last, dw_hs_last, dw_sat;

  assign adv        = !dw_valid || dw_ready;
  assign z_hs       = z_valid && z_ready;
  assign z_last     = (rem_q == CNT_W'(1));
  assign dw_hs_last = dw_valid && dw_ready && dw_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = (n_steps == '0) ? IDLE : WAIT_SCALE;
      WAIT_SCALE: if (sqrt_valid) state_d = RUN;
      RUN:        if (z_hs && z_last) state_d = DRAIN;
      DRAIN:      if (dw_hs_last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    z_ready = (state_q == RUN) && (rem_q != '0) && adv;
    busy    = (state_q != IDLE);
  end

  always_comb begin
    rem_d   = rem_q;
    scale_d = scale_q;
    done_d  = 1'b0;
    sat_d   = sat_q | (dw_valid & dw_sat);
    if (state_q == IDLE && start) begin
      rem_d  = n_steps;
      sat_d  = 1'b0;
      done_d = (n_steps == '0);
    end
    if (state_q == WAIT_SCALE && sqrt_valid) scale_d = sqrt_in;
    if (z_hs) rem_d = rem_q - CNT_W'(1);
    if (state_q == DRAIN && dw_hs_last) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      scale_q <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      scale_q <= scale_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  fx_mul_rs u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (adv),
    .valid_i (z_hs),
    .tag_i   (z_last),
    .a_i     (z_data),
    .b_i     (scale_q),
    .valid_o (dw_valid),
    .tag_o   (dw_last),
    .sat_o   (dw_sat),
    .data_o  (dw_data)
  );

  assign done = done_q;
  // Flag rises with the saturated dW itself, then the sticky bit holds it.
  assign sat_flag = sat_q | (dw_valid & dw_sat);

endmodule

// File: tb/tb_brownian_increment.sv
// Directed bench for brownian_increment: hand-computed dW vectors, stalls,
// saturation, zero-length path and mid-run reset.
module tb_brownian_increment;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_steps;
  logic        sqrt_valid;
  logic [31:0] sqrt_in;
  logic        z_valid;
  logic [31:0] z_data;
  logic        z_ready;
  logic        dw_valid;
  logic [31:0] dw_data;
  logic        dw_last;
  logic        dw_ready;
  logic        busy, done, sat_flag;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] zv [16];
  logic [31:0] ev [16];
  logic [31:0] dq [$];
  logic        lq [$];
  int          dcyc [$];
  int          zcyc [$];
  int          done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int          stall_viol = 0, zr_viol = 0, stall_obs = 0, last_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  brownian_increment #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_steps    (n_steps),
    .sqrt_valid (sqrt_valid),
    .sqrt_in    (sqrt_in),
    .z_valid    (z_valid),
    .z_data     (z_data),
    .z_ready    (z_ready),
    .dw_valid   (dw_valid),
    .dw_data    (dw_data),
    .dw_last    (dw_last),
    .dw_ready   (dw_ready),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Inputs settle 1 ns after posedge, so the negedge sees what the next posedge samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (z_valid && z_ready) zcyc.push_back(cyc);
      if (dw_valid && dw_ready) begin
        dq.push_back(dw_data);
        lq.push_back(dw_last);
        dcyc.push_back(cyc);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (dw_last && !dw_valid) last_viol <= last_viol + 1;
      if (dw_valid && !dw_ready && z_ready) zr_viol <= zr_viol + 1;
      if (prev_stall && (!dw_valid || dw_data !== prev_data || dw_last !== prev_last))
        stall_viol <= stall_viol + 1;
      if (dw_valid && !dw_ready) stall_obs <= stall_obs + 1;
      prev_stall <= dw_valid && !dw_ready;
      prev_data  <= dw_data;
      prev_last  <= dw_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic run_path(input string nm, input int n, input logic [31:0] scale,
                          input int stall_at, input int stall_len);
    int d0, dc0, i, t, got_n;
    d0  = dq.size();
    dc0 = done_cnt;
    @(posedge clk); #1;
    start   = 1'b1;
    n_steps = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s_busy", nm), 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    sqrt_valid = 1'b1;
    sqrt_in    = scale;
    @(posedge clk); #1;
    sqrt_valid = 1'b0;
    i = 0;
    t = 0;
    while (done_cnt == dc0 && t < 300) begin
      z_valid    = (i < n);
      z_data     = (i < n) ? zv[i] : 32'h0;
      dw_ready   = !(t >= stall_at && t < stall_at + stall_len);
      sqrt_valid = (t == 1);
      sqrt_in    = (t == 1) ? 32'hDEAD0000 : scale;
      @(negedge clk);
      if (z_valid && z_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    z_valid    = 1'b0;
    sqrt_valid = 1'b0;
    dw_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s_done_pulses", nm), 32'(done_cnt - dc0), 32'd1);
    check($sformatf("%s_busy_end", nm), 32'(busy), 32'd0);
    got_n = dq.size() - d0;
    check($sformatf("%s_count", nm), 32'(got_n), 32'(n));
    for (int k = 0; k < n && k < got_n; k++) begin
      check($sformatf("%s_dw%0d", nm, k), dq[d0+k], ev[k]);
      check($sformatf("%s_last%0d", nm, k), 32'(lq[d0+k]), 32'(k == n-1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, z0, dc0, b0, s0;
    rst_n = 1'b0; start = 1'b0; n_steps = '0; sqrt_valid = 1'b0; sqrt_in = '0;
    z_valid = 1'b0; z_data = '0; dw_ready = 1'b1;
    #1;
    check("rst_outputs", {25'b0, dw_valid, dw_last, z_ready, busy, done, sat_flag, 1'b0}, 32'd0);
    check("rst_dw_data", dw_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unit scale: dW equals z, 2-cycle latency, last on 3rd only.
    zv[0] = 32'h00018000; zv[1] = 32'hFFFF0000; zv[2] = 32'h00000000;
    ev[0] = 32'h00018000; ev[1] = 32'hFFFF0000; ev[2] = 32'h00000000;
    d0 = dq.size(); z0 = zcyc.size();
    run_path("unit", 3, 32'h00010000, 1000, 0);
    for (int k = 0; k < 3; k++)
      check($sformatf("unit_latency%0d", k), 32'(dcyc[d0+k] - zcyc[z0+k]), 32'd2);
    check("unit_done_timing", 32'(done_cyc), 32'(dcyc[d0+2] + 1));
    check("unit_throughput", 32'(zcyc[z0+2] - zcyc[z0]), 32'd2);

    zv[0] = 32'hFFFE0000; ev[0] = 32'hFFFFCCCC;
    run_path("sqrt001", 1, 32'h0000199A, 1000, 0);
    zv[0] = 32'h00000001; ev[0] = 32'h00000001;
    run_path("round_half", 1, 32'h00008000, 1000, 0);
    check("no_sat_yet", 32'(sat_flag), 32'd0);

    zv[0] = 32'h7FFF0000; ev[0] = 32'h7FFFFFFF;
    zv[1] = 32'h80000000; ev[1] = 32'h80000000;
    run_path("sat", 2, 32'h00100000, 1000, 0);
    check("sat_flag_set", 32'(sat_flag), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("sat_flag_sticky", 32'(sat_flag), 32'd1);

    // Scale 2.0 with a 5-cycle downstream stall mid-burst.
    zv[0] = 32'h00001000; ev[0] = 32'h00002000;
    zv[1] = 32'h00002000; ev[1] = 32'h00004000;
    zv[2] = 32'h00003000; ev[2] = 32'h00006000;
    zv[3] = 32'h00004000; ev[3] = 32'h00008000;
    zv[4] = 32'hFFFFF000; ev[4] = 32'hFFFFE000;
    zv[5] = 32'hFFFFE000; ev[5] = 32'hFFFFC000;
    zv[6] = 32'h00010000; ev[6] = 32'h00020000;
    zv[7] = 32'h00000003; ev[7] = 32'h00000006;
    s0 = stall_obs;
    run_path("stall", 8, 32'h00020000, 4, 5);
    check("stall_seen", 32'(stall_obs > s0), 32'd1);
    check("stall_hold", 32'(stall_viol), 32'd0);
    check("stall_zready", 32'(zr_viol), 32'd0);
    check("sat_cleared_by_start", 32'(sat_flag), 32'd0);
    check("last_only_valid", 32'(last_viol), 32'd0);

    // Zero-length path with a coincident sqrt_valid.
    dc0 = done_cnt; b0 = busy_cnt; d0 = dq.size();
    @(posedge clk); #1;
    start = 1'b1; n_steps = 16'd0; sqrt_valid = 1'b1; sqrt_in = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0; sqrt_valid = 1'b0;
    check("n0_busy", 32'(busy), 32'd0);
    check("n0_done", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("n0_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("n0_busy_cnt", 32'(busy_cnt - b0), 32'd0);
    check("n0_no_dw", 32'(dq.size() - d0), 32'd0);

    // Reset with two samples in flight.
    start = 1'b1; n_steps = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; sqrt_valid = 1'b1; sqrt_in = 32'h00010000;
    @(posedge clk); #1;
    sqrt_valid = 1'b0; z_valid = 1'b1; z_data = 32'h00010000;
    @(posedge clk); #1;
    z_data = 32'h00020000;
    @(posedge clk); #1;
    z_valid = 1'b0;
    check("inflight_valid", 32'(dw_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {26'b0, dw_valid, dw_last, z_ready, busy, done, sat_flag}, 32'd0);
    check("mid_rst_dw_data", dw_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    zv[0] = 32'h00050000; ev[0] = 32'h00050000;
    run_path("post_rst", 1, 32'h00010000, 1000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
